counter_sched: RTL and testbench

Run-to-terminal-count scheduler for the 4-bit toggle-enable counter. Two requesters share one counter: each submits a terminal count through a valid/ready handshake, and a round-robin arbiter grants the counter to one requester at a time. The block clears the counter, drives its per-bit toggle enables until the count reaches the granted terminal value or the run is aborted, then reports completion. The counter is instantiated inside this block. It sits between the control plane and the counter datapath.

---
 rtl/counter_sched.sv | 138 +++++++++++++
 tb/tb_counter_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sched.sv
// counter_sched
//   Run-to-terminal-count scheduler wrapped around a 4-bit toggle-enable
//   counter. Two requesters offer a terminal count over valid/ready. A
//   round-robin arbiter picks one, the counter is cleared and stepped until it
//   equals the latched terminal count (or the run is aborted). A one-cycle
//   done pulse follows, then GAP idle cycles before the next grant.
//
// Parameters
//   GAP          idle cycles between DONE and the next grant (0..3)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   req_valid    [1:0] per-requester command pending
//   req_tc0      [3:0] terminal count of requester 0
//   req_tc1      [3:0] terminal count of requester 1
//   req_ready    [1:0] per-requester accept (one-hot, IDLE only)
//   abort        end the current run early (ignored outside RUN)
//   busy         high in RUN, DONE and GAP
//   grant_id     requester owning the current or last run
//   cnt_q        [3:0] counter value
//   cnt_t        [3:0] toggle enables applied at the coming edge
//   done         one-cycle completion pulse
//   done_aborted qualifies done: the run was aborted
module counter_sched #(
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [3:0] req_tc0,
  input  logic [3:0] req_tc1,
  output logic [1:0] req_ready,
  input  logic       abort,
  output logic       busy,
  output logic       grant_id,
  output logic [3:0] cnt_q,
  output logic [3:0] cnt_t,
  output logic       done,
  output logic       done_aborted
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Value loaded into the gap down-counter on leaving DONE; GAP state exits
  // when the counter reads zero, so it is loaded with GAP-1.
  localparam logic [1:0] GAP_LAST = (GAP > 0) ? 2'(GAP - 1) : 2'd0;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] tc;
  logic       prio;       // requester that wins when both are valid
  logic       aborted;
  logic [1:0] gap_cnt;
  logic       sel;
  logic       hs;
  logic       match;
  logic       inc;

  // Toggle enables for a ripple-free binary increment: bit i flips when all
  // lower bits are 1.
  function automatic logic [3:0] toggle_en(input logic en, input logic [3:0] q);
    toggle_en = {en & q[0] & q[1] & q[2], en & q[0] & q[1], en & q[0], en};
  endfunction

  always_comb begin
    case (req_valid)
      2'b10:   sel = 1'b1;
      2'b11:   sel = prio;
      default: sel = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    hs        = 1'b0;
    inc       = 1'b0;
    match     = (cnt_q == tc);
    case (state)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready = sel ? 2'b10 : 2'b01;
          hs        = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Match outranks abort; neither increments in the stopping cycle.
        if (match || abort) state_nxt = ST_DONE;
        else                inc       = 1'b1;
      end
      ST_DONE: begin
        state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt == 2'd0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cnt_t        = toggle_en(inc, cnt_q);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign done_aborted = (state == ST_DONE) && aborted;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      tc       <= 4'd0;
      grant_id <= 1'b0;
      prio     <= 1'b0;
      cnt_q    <= 4'd0;
      aborted  <= 1'b0;
      gap_cnt  <= 2'd0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        tc       <= sel ? req_tc1 : req_tc0;
        grant_id <= sel;
        prio     <= ~sel;
        cnt_q    <= 4'd0;
      end else begin
        cnt_q <= cnt_q ^ cnt_t;
      end
      if (state == ST_RUN) aborted <= ~match & abort;
      if (state == ST_DONE) gap_cnt <= GAP_LAST;
      else if (state == ST_GAP && gap_cnt != 2'd0) gap_cnt <= gap_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched
//   Directed bench for counter_sched. Main instance uses GAP=1, a second
//   instance uses GAP=0 for back-to-back and withdrawn-request scenarios.
module tb_counter_sched;

  logic       clk;
  logic       reset;
  logic [1:0] req_valid;
  logic [3:0] req_tc0;
  logic [3:0] req_tc1;
  logic [1:0] req_ready;
  logic       abort;
  logic       busy;
  logic       grant_id;
  logic [3:0] cnt_q;
  logic [3:0] cnt_t;
  logic       done;
  logic       done_aborted;

  logic [1:0] z_valid;
  logic [3:0] z_tc0;
  logic [3:0] z_tc1;
  logic [1:0] z_ready;
  logic       z_abort;
  logic       z_busy;
  logic       z_grant;
  logic [3:0] z_cnt_q;
  logic [3:0] z_cnt_t;
  logic       z_done;
  logic       z_done_ab;

  int n_vec;
  int n_err;

  counter_sched #(.GAP(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_tc0(req_tc0),
    .req_tc1(req_tc1), .req_ready(req_ready), .abort(abort), .busy(busy),
    .grant_id(grant_id), .cnt_q(cnt_q), .cnt_t(cnt_t), .done(done),
    .done_aborted(done_aborted)
  );

  counter_sched #(.GAP(0)) dut_g0 (
    .clk(clk), .reset(reset), .req_valid(z_valid), .req_tc0(z_tc0),
    .req_tc1(z_tc1), .req_ready(z_ready), .abort(z_abort), .busy(z_busy),
    .grant_id(z_grant), .cnt_q(z_cnt_q), .cnt_t(z_cnt_t), .done(z_done),
    .done_aborted(z_done_ab)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Move to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    req_valid = 2'b00; req_tc0 = 4'd0; req_tc1 = 4'd0; abort = 1'b0;
    z_valid = 2'b00; z_tc0 = 4'd0; z_tc1 = 4'd0; z_abort = 1'b0;

    // Reset state
    #3;
    chk("rst_busy",  busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_cnt",   cnt_q, 0);
    chk("rst_cnt_t", cnt_t, 0);
    chk("rst_done",  {done, done_aborted}, 0);
    chk("rst_gid",   grant_id, 0);
    tick();
    reset = 1'b1;
    tick();

    // Single request tc=5, GAP=1
    req_tc0 = 4'd5; req_valid = 2'b01;
    #1 chk("t5_ready", req_ready, 2'b01);
    chk("t5_idle_busy", busy, 0);
    tick();                       // handshake edge 0 -> cycle 1
    req_valid = 2'b00;
    for (int n = 0; n <= 5; n++) begin
      chk("t5_cnt", cnt_q, n);
      chk("t5_busy", busy, 1);
      chk("t5_nodone", done, 0);
      if (n == 1) chk("t5_cnt_t_1to2", cnt_t, 4'b0011);
      if (n == 5) chk("t5_cnt_t_match", cnt_t, 4'b0000);
      tick();
    end
    chk("t5_done", done, 1);      // cycle 7
    chk("t5_dab", done_aborted, 0);
    chk("t5_gid", grant_id, 0);
    chk("t5_hold", cnt_q, 5);
    tick();
    chk("t5_gap_busy", {busy, done}, 2'b10);   // cycle 8
    tick();
    chk("t5_idle", busy, 0);                    // cycle 9
    chk("t5_idle_cnt", cnt_q, 5);

    // tc=0
    req_tc0 = 4'd0; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    chk("t0_cnt", cnt_q, 0);
    chk("t0_cnt_t", cnt_t, 0);
    chk("t0_nodone", done, 0);
    tick();
    chk("t0_done", {done, done_aborted}, 2'b10);
    chk("t0_cnt_done", cnt_q, 0);
    tick(); tick();
    chk("t0_idle", busy, 0);

    // tc=15
    req_tc0 = 4'd15; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    for (int n = 0; n <= 15; n++) begin
      chk("t15_cnt", cnt_q, n);
      if (n == 7) chk("t15_cnt_t_7to8", cnt_t, 4'b1111);
      if (n == 15) chk("t15_cnt_t_match", cnt_t, 4'b0000);
      tick();
    end
    chk("t15_done", done, 1);
    chk("t15_nowrap", cnt_q, 15);
    tick(); tick();
    chk("t15_idle", busy, 0);

    // Reset mid-run
    req_tc0 = 4'd9; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    repeat (5) tick();
    chk("mr_cnt5", cnt_q, 5);
    reset = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_cnt", cnt_q, 0);
    chk("mr_cnt_t", cnt_t, 0);
    chk("mr_done", {done, done_aborted}, 0);
    chk("mr_ready", req_ready, 0);
    #3 reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mr_post", {busy, done}, 0);
    end

    // Both requesters valid: grants alternate 0,1,0,1
    req_tc0 = 4'd2; req_tc1 = 4'd1; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_ready", req_ready, (i % 2) ? 2'b10 : 2'b01);
      tick();
      chk("rr_ready_run", req_ready, 0);
      repeat ((i % 2) ? 2 : 3) tick();
      chk("rr_done", done, 1);
      chk("rr_gid", grant_id, i % 2);
      chk("rr_cnt", cnt_q, (i % 2) ? 1 : 2);
      tick();
      chk("rr_gap_ready", req_ready, 0);
      tick();
    end
    req_valid = 2'b00;

    // Abort at cnt_q=3 with tc=9
    req_tc0 = 4'd9; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    repeat (3) tick();
    chk("ab_cnt3", cnt_q, 3);
    abort = 1'b1;
    #1 chk("ab_cnt_t", cnt_t, 0);
    tick();
    abort = 1'b0;
    chk("ab_done", {done, done_aborted}, 2'b11);
    chk("ab_hold", cnt_q, 3);
    tick();
    chk("ab_gap_cnt", cnt_q, 3);
    tick();

    // Abort coinciding with match
    req_tc0 = 4'd2; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abm_done", {done, done_aborted}, 2'b10);
    chk("abm_cnt", cnt_q, 2);
    tick(); tick();

    // Abort in IDLE
    abort = 1'b1;
    repeat (3) begin
      tick();
      chk("abi_state", {busy, done, done_aborted}, 0);
      chk("abi_cnt", cnt_q, 2);
    end
    abort = 1'b0;

    // GAP=0 instance: back-to-back runs and withdrawn requester 1
    z_tc0 = 4'd1; z_tc1 = 4'd4; z_valid = 2'b01;
    #1 chk("g0_ready0", z_ready, 2'b01);
    tick();                                   // handshake k
    z_valid = 2'b11;
    #1 chk("g0_run_ready", z_ready, 0);
    chk("g0_cnt0", z_cnt_q, 0);
    tick();
    z_valid = 2'b01;                          // requester 1 withdraws
    chk("g0_cnt1", z_cnt_q, 1);
    tick();
    chk("g0_done", {z_done, z_grant}, 2'b10);
    tick();                                   // k+4: IDLE again
    chk("g0_idle", z_busy, 0);
    #1 chk("g0_b2b_ready", z_ready, 2'b01);
    tick();
    chk("g0_run2", {z_busy, z_cnt_q}, 5'b10000);
    tick(); tick();
    chk("g0_done2", {z_done, z_grant}, 2'b10);
    tick();
    z_valid = 2'b11;
    #1 chk("g0_rr_ready", z_ready, 2'b10);
    z_valid = 2'b00;
    tick();
    chk("g0_nohs", z_busy, 0);
    z_valid = 2'b11;
    #1 chk("g0_ptr_kept", z_ready, 2'b10);
    z_valid = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
